// File: rtl/tdot_stream.sv
// Streaming multi-lane signed dot-product engine with valid/ready backpressure.
// Beats flow through multiply, an add chain and a per-lane group accumulator.
module tdot_stream #(
  parameter int WIDTH = 8,
  parameter int LANES = 5,
  parameter int DEPTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [LANES*DEPTH*WIDTH-1:0] in_a,
  input  logic [LANES*DEPTH*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0]       in_bias,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int SW = LANES * WIDTH;
  localparam int PW = DEPTH * SW;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_MID   = 1'b1;

  logic          adv;
  logic          out_valid_q;
  logic [SW-1:0] out_data_q;
  logic [SW-1:0] acc_q;

  // A single advance enable freezes every stage while the output is stalled.
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  logic [0:0] state_q, state_d;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (in_valid && adv) state_d = in_last ? ST_FIRST : ST_MID;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_FIRST;
    else        state_q <= state_d;
  end

  logic [PW-1:0] a0_q, b0_q;
  logic [SW-1:0] bias0_q;
  logic          valid0_q, last0_q, first0_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a0_q     <= '0;
      b0_q     <= '0;
      bias0_q  <= '0;
      valid0_q <= 1'b0;
      last0_q  <= 1'b0;
      first0_q <= 1'b0;
    end else if (adv) begin
      a0_q     <= in_a;
      b0_q     <= in_b;
      bias0_q  <= in_bias;
      valid0_q <= in_valid;
      last0_q  <= in_last;
      first0_q <= (state_q == ST_FIRST);
    end
  end

  // Products are packed term-major so each chain stage peels off the low lane block.
  // The low WIDTH bits of a product do not depend on operand signedness.
  logic [PW-1:0] prod_d, prod1_q;
  logic [SW-1:0] bias1_q;
  logic          valid1_q, last1_q, first1_q;

  always_comb begin
    prod_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < LANES; l++) begin
        prod_d[(k*LANES+l)*WIDTH +: WIDTH] =
          a0_q[(l*DEPTH+k)*WIDTH +: WIDTH] * b0_q[(l*DEPTH+k)*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod1_q  <= '0;
      bias1_q  <= '0;
      valid1_q <= 1'b0;
      last1_q  <= 1'b0;
      first1_q <= 1'b0;
    end else if (adv) begin
      prod1_q  <= prod_d;
      bias1_q  <= bias0_q;
      valid1_q <= valid0_q;
      last1_q  <= last0_q;
      first1_q <= first0_q;
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_chain
    localparam int RW = (DEPTH - s) * SW;

    logic [RW-1:0] rest_in;
    logic [SW-1:0] base_in;
    logic          v_in, l_in, f_in;
    logic [SW-1:0] sum_d, sum_q;
    logic          v_q, l_q, f_q;

    if (s == 0) begin : g_head
      assign rest_in = prod1_q;
      assign base_in = first1_q ? bias1_q : '0;
      assign v_in    = valid1_q;
      assign l_in    = last1_q;
      assign f_in    = first1_q;
    end else begin : g_link
      assign rest_in = g_chain[s-1].g_keep.rest_q;
      assign base_in = g_chain[s-1].sum_q;
      assign v_in    = g_chain[s-1].v_q;
      assign l_in    = g_chain[s-1].l_q;
      assign f_in    = g_chain[s-1].f_q;
    end

    always_comb begin
      sum_d = '0;
      for (int l = 0; l < LANES; l++) begin
        sum_d[l*WIDTH +: WIDTH] = base_in[l*WIDTH +: WIDTH] + rest_in[l*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sum_q <= '0;
        v_q   <= 1'b0;
        l_q   <= 1'b0;
        f_q   <= 1'b0;
      end else if (adv) begin
        sum_q <= sum_d;
        v_q   <= v_in;
        l_q   <= l_in;
        f_q   <= f_in;
      end
    end

    if (s < DEPTH - 1) begin : g_keep
      logic [RW-SW-1:0] rest_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset)   rest_q <= '0;
        else if (adv) rest_q <= rest_in[RW-1:SW];
      end
    end
  end

  logic [SW-1:0] fin_sum, total;
  logic          fin_v, fin_l, fin_f;

  assign fin_sum = g_chain[DEPTH-1].sum_q;
  assign fin_v   = g_chain[DEPTH-1].v_q;
  assign fin_l   = g_chain[DEPTH-1].l_q;
  assign fin_f   = g_chain[DEPTH-1].f_q;

  // A first beat loads the accumulator rather than adding to stale contents.
  always_comb begin
    total = '0;
    for (int l = 0; l < LANES; l++) begin
      total[l*WIDTH +: WIDTH] = (fin_f ? '0 : acc_q[l*WIDTH +: WIDTH]) + fin_sum[l*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= fin_v && fin_l;
      if (fin_v) begin
        if (fin_l) begin
          out_data_q <= total;
          acc_q      <= '0;
        end else begin
          acc_q <= total;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdot_stream.sv
// Directed and table-driven bench for tdot_stream, plus a small-parameter
// instance checked against a scoreboard model under random traffic.
module tb_tdot_stream;

  localparam int W   = 8;
  localparam int L   = 5;
  localparam int D   = 3;
  localparam int LAT = D + 2;  // posedges from acceptance edge to out_valid

  logic               clock = 1'b0;
  logic               reset;
  logic [L*D*W-1:0]   in_a, in_b;
  logic [L*W-1:0]     in_bias;
  logic               in_last, in_valid, in_ready;
  logic [L*W-1:0]     out_data;
  logic               out_valid, out_ready;

  logic [31:0] a2, b2, bias2, data2;
  logic        last2, valid2, ready2, ovalid2, oready2;

  always #5 clock = ~clock;

  tdot_stream #(.WIDTH(W), .LANES(L), .DEPTH(D)) u_dut (
    .clock(clock), .reset(reset), .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));

  tdot_stream #(.WIDTH(16), .LANES(2), .DEPTH(1)) u_dut2 (
    .clock(clock), .reset(reset), .in_a(a2), .in_b(b2), .in_bias(bias2),
    .in_last(last2), .in_valid(valid2), .in_ready(ready2),
    .out_data(data2), .out_valid(ovalid2), .out_ready(oready2));

  typedef logic [0:2][7:0] trio_t;
  typedef struct packed {
    trio_t      a;
    trio_t      b;
    logic [7:0] bias;
    logic [7:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [L*W-1:0] lanes_exp(input logic [7:0] e);
    logic [L*W-1:0] r;
    for (int l = 0; l < L; l++) r[l*W +: W] = e + 8'(l);
    return r;
  endfunction

  task automatic set_beat(input trio_t a, input trio_t b, input logic [7:0] bias, input logic last);
    for (int l = 0; l < L; l++) begin
      for (int k = 0; k < D; k++) begin
        in_a[(l*D+k)*W +: W] = a[k];
        in_b[(l*D+k)*W +: W] = b[k];
      end
      in_bias[l*W +: W] = bias + 8'(l);
    end
    in_last = last;
  endtask

  // Presents one beat for a single edge; callers keep out_ready high so it is taken.
  task automatic drive(input trio_t a, input trio_t b, input logic [7:0] bias, input logic last);
    set_beat(a, b, bias, last);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  vec_t           vecs [7];
  trio_t          t111, t120, t320, t200, t300;
  int             n, pulses, early, g_sent, got, beats, nres;
  logic [L*W-1:0] cap, held;
  bit             stalled_prev;
  logic [31:0]    acc_m, exp2;
  bit             first_m;
  logic [31:0]    sbq [$];

  task automatic sweep_out_step();
    if (ovalid2 && oready2) begin
      if (sbq.size() == 0) begin
        check("sweep_extra", 64'(ovalid2), 64'd0);
      end else begin
        exp2 = sbq.pop_front();
        check($sformatf("sweep_res%0d", nres), 64'(data2), 64'(exp2));
        nres++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{a: {8'd1, 8'd2, 8'd3},     b: {8'd4, 8'd5, 8'd6},     bias: 8'd10,  exp: 8'd42};
    vecs[1] = '{a: {8'd127, 8'd0, 8'd0},   b: {8'd2, 8'd0, 8'd0},     bias: 8'd0,   exp: 8'hFE};
    vecs[2] = '{a: {8'h80, 8'd0, 8'd0},    b: {8'hFF, 8'd0, 8'd0},    bias: 8'd0,   exp: 8'h80};
    vecs[3] = '{a: {8'hFD, 8'd4, 8'd5},    b: {8'd7, 8'hFE, 8'd3},    bias: 8'hFF,  exp: 8'hF1};
    vecs[4] = '{a: {8'd16, 8'd16, 8'd0},   b: {8'd16, 8'd1, 8'd0},    bias: 8'd0,   exp: 8'd16};
    vecs[5] = '{a: {8'd100, 8'd100, 8'd0}, b: {8'd1, 8'd1, 8'd0},     bias: 8'd100, exp: 8'd44};
    vecs[6] = '{a: {8'hFF, 8'hFF, 8'hFF},  b: {8'hFF, 8'hFF, 8'hFF},  bias: 8'h80,  exp: 8'h83};
    t111 = {8'd1, 8'd1, 8'd1};
    t120 = {8'd1, 8'd2, 8'd0};
    t320 = {8'd3, 8'd2, 8'd0};
    t200 = {8'd2, 8'd0, 8'd0};
    t300 = {8'd3, 8'd0, 8'd0};

    in_a = '0; in_b = '0; in_bias = '0; in_last = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; reset = 1'b0;
    a2 = '0; b2 = '0; bias2 = '0; last2 = 1'b0; valid2 = 1'b0; oready2 = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();

    // Table of single-beat groups
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].bias, 1'b1);
      wait_out(n);
      check($sformatf("lat_v%0d", i), 64'(n), 64'(LAT));
      check($sformatf("data_v%0d", i), 64'(out_data), 64'(lanes_exp(vecs[i].exp)));
      tick();
    end

    // Two-beat group: second-beat bias ignored, one result pulse
    drive(t111, t111, 8'd5, 1'b0);
    drive(t111, t111, 8'd99, 1'b1);
    pulses = 0; cap = '0;
    repeat (12) begin
      if (out_valid) begin
        pulses++;
        cap = out_data;
      end
      tick();
    end
    check("grp2_pulses", 64'(pulses), 64'd1);
    check("grp2_data", 64'(cap), 64'(lanes_exp(8'd11)));

    // Bubbles inside a group
    drive(t111, t111, 8'd5, 1'b0);
    early = 0;
    repeat (3) begin
      if (out_valid) early++;
      tick();
    end
    if (out_valid) early++;
    drive(t111, t111, 8'd99, 1'b1);
    wait_out(n);
    check("bub_early", 64'(early), 64'd0);
    check("bub_lat", 64'(n), 64'(LAT));
    check("bub_data", 64'(out_data), 64'(lanes_exp(8'd11)));
    tick();

    // Reset mid-group while a held result is stalled at the output
    out_ready = 1'b0;
    drive(vecs[0].a, vecs[0].b, vecs[0].bias, 1'b1);
    drive(t120, t320, 8'd0, 1'b0);
    wait_out(n);
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    repeat (2) tick();
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_hold", 64'(out_data), 64'(lanes_exp(8'd42)));
    #2 reset = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_data", 64'(out_data), 64'd0);
    @(posedge clock);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    drive(t200, t300, 8'd1, 1'b1);
    wait_out(n);
    check("rst_lat", 64'(n), 64'(LAT));
    check("rst_data", 64'(out_data), 64'(lanes_exp(8'd7)));
    tick();

    // Backpressure: 8 single-beat groups, out_ready pattern 1,0,0,1
    g_sent = 0; got = 0; stalled_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (g_sent < 8) begin
        set_beat({8'(g_sent), 8'd1, 8'd0}, {8'd2, 8'(g_sent), 8'd0}, 8'(g_sent), 1'b1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #3;
      if (stalled_prev) begin
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_data", 64'(out_data), 64'(held));
      end
      if (out_valid) check("bp_ready_eq", 64'(in_ready), 64'(out_ready));
      if (out_valid && out_ready) begin
        check($sformatf("bp_res%0d", got), 64'(out_data), 64'(lanes_exp(8'(4 * got))));
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) g_sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      if (out_valid) got++;
      tick();
    end
    check("bp_count", 64'(got), 64'd8);

    // Small-parameter instance against a scoreboard model
    beats = 0; nres = 0; first_m = 1'b1; acc_m = '0;
    for (int cyc = 0; cyc < 4000 && beats < 300; cyc++) begin
      valid2  = $urandom_range(0, 3) != 0;
      a2      = $urandom;
      b2      = $urandom;
      bias2   = $urandom;
      last2   = $urandom_range(0, 2) == 0;
      oready2 = $urandom_range(0, 3) != 0;
      #3;
      sweep_out_step();
      if (valid2 && ready2) begin
        for (int l = 0; l < 2; l++) begin
          logic [15:0] x, y, t;
          x = a2[l*16 +: 16];
          y = b2[l*16 +: 16];
          t = x * y;
          acc_m[l*16 +: 16] = (first_m ? bias2[l*16 +: 16] : acc_m[l*16 +: 16]) + t;
        end
        if (last2) sbq.push_back(acc_m);
        first_m = last2;
        beats++;
      end
      tick();
    end
    valid2 = 1'b0;
    oready2 = 1'b1;
    repeat (20) begin
      #3;
      sweep_out_step();
      tick();
    end
    check("sweep_left", 64'(sbq.size()), 64'd0);
    check("sweep_beats", 64'(beats), 64'd300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
